fetch_ctrl: RTL and testbench

Fetch-stage sequencer for the mini RISC-V core. Owns the fetch PC, issues one instruction-memory request at a time, and buffers the returned instruction toward decode. Drives the combinational static predictor (`pre_if`-style block: instr + pc in, predicted next pc out) with each instruction as it enters the output slot, then uses the predicted PC as the next fetch address. Handles redirects from execute, including killing in-flight responses.

---
 rtl/fetch_ctrl.sv | 105 ++++++++++
 tb/tb_fetch_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, issues one imem request at a time and
// buffers the returned instruction (plus a one-deep hold slot) toward decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pred_instr,
  output logic [31:0] pred_pc,
  input  logic [31:0] pre_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pred_pc
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StDrop} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  assign imem_req   = (state == StReq) && !rst;
  assign imem_addr  = fetch_pc;
  // The predictor always sees whatever is about to enter the output slot.
  assign pred_instr = (state == StHold) ? hold_instr : imem_rdata;
  assign pred_pc    = (state == StHold) ? hold_pc : fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StReq;
      fetch_pc   <= RESET_PC;
      if_valid   <= 1'b0;
      if_instr   <= 32'h0;
      if_pc      <= 32'h0;
      if_pred_pc <= 32'h0;
      hold_instr <= 32'h0;
      hold_pc    <= 32'h0;
    end else if (redirect_valid) begin
      if_valid   <= 1'b0;
      hold_instr <= 32'h0;
      hold_pc    <= 32'h0;
      fetch_pc   <= redirect_pc;
      // Go to DROP only while a granted response is still owed to us.
      unique case (state)
        StReq:          state <= imem_gnt ? StDrop : StReq;
        StWait, StDrop: state <= imem_rvalid ? StReq : StDrop;
        default:        state <= StReq;
      endcase
    end else begin
      if (id_ready && if_valid) begin
        if_valid <= 1'b0;
      end
      unique case (state)
        StReq: begin
          if (imem_gnt) begin
            state <= StWait;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            if (!if_valid || id_ready) begin
              if_valid   <= 1'b1;
              if_instr   <= pred_instr;
              if_pc      <= pred_pc;
              if_pred_pc <= pre_pc;
              fetch_pc   <= pre_pc;
              state      <= StReq;
            end else begin
              hold_instr <= imem_rdata;
              hold_pc    <= fetch_pc;
              state      <= StHold;
            end
          end
        end
        StHold: begin
          if (id_ready) begin
            if_valid   <= 1'b1;
            if_instr   <= pred_instr;
            if_pc      <= pred_pc;
            if_pred_pc <= pre_pc;
            fetch_pc   <= pre_pc;
            state      <= StReq;
          end
        end
        StDrop: begin
          if (imem_rvalid) begin
            state <= StReq;
          end
        end
        default: state <= StReq;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written redirect/hold/reset sequences,
// and a randomized run checked against an ideal program-order instruction stream.
module tb_fetch_ctrl;

  localparam logic [31:0] RstPc = 32'h0000_0100;
  localparam logic [31:0] Addi  = 32'h0010_8093;  // addi x1,x1,1
  localparam logic [31:0] BeqM16 = 32'hFE00_08E3; // beq x0,x0,-16
  localparam logic [31:0] BeqP8 = 32'h0000_0463;  // beq x0,x0,+8
  localparam logic [31:0] Jal40 = 32'h0400_006F;  // jal x0,+0x40

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pred_instr;
  logic [31:0] pred_pc;
  logic [31:0] pre_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pred_pc;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  // Static predictor: JAL taken, backward conditional branches taken, else pc+4.
  function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] ins);
    logic [31:0] immj;
    logic [31:0] immb;
    immj = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    immb = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    if (ins[6:0] == 7'h6F) return pc + immj;
    if (ins[6:0] == 7'h63 && ins[31]) return pc + immb;
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] memword(input logic [31:0] addr);
    logic [31:0] h;
    h = (addr >> 2) * 32'h9E37_79B1;
    if (h[31:28] < 4'd9) return Addi;
    if (h[31:28] < 4'd11) return BeqP8;
    if (h[31:28] < 4'd13) return BeqM16;
    return Jal40;
  endfunction

  assign pre_pc = predict(pred_pc, pred_instr);

  fetch_ctrl #(.RESET_PC(RstPc)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .pred_instr    (pred_instr),
    .pred_pc       (pred_pc),
    .pre_pc        (pre_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pred_pc    (if_pred_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        idr;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pred;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic g, input logic rv, input logic [31:0] d, input logic idr,
                     input logic rd, input logic [31:0] rpc, input logic er,
                     input logic [31:0] ea, input logic ev, input logic [31:0] epc,
                     input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v = '{gnt: g, rv: rv, rdata: d, idr: idr, redir: rd, rpc: rpc, e_req: er, e_addr: ea,
          e_v: ev, e_pc: epc, e_instr: ei, e_pred: ep};
    vt.push_back(v);
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] d, input logic idr,
                       input logic rd, input logic [31:0] rpc);
    imem_gnt       = g;
    imem_rvalid    = rv;
    imem_rdata     = d;
    id_ready       = idr;
    redirect_valid = rd;
    redirect_pc    = rpc;
  endtask

  task automatic step(input logic g, input logic rv, input logic [31:0] d, input logic idr,
                      input logic rd, input logic [31:0] rpc);
    drive(g, rv, d, idr, rd, rpc);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RstPc);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pred", if_pred_pc, 32'h0);
    rst = 1'b0;

    // ---------------- directed vector table ----------------
    //  gnt rv  rdata  idr rd rpc   | req addr  v pc  instr pred
    add(1, 0, 32'h0,  1, 0, 32'h0,   1, 32'h100, 0, 0, 0, 0);
    add(0, 1, Addi,   1, 0, 32'h0,   0, 32'h100, 0, 0, 0, 0);
    add(1, 0, 32'h0,  1, 0, 32'h0,   1, 32'h104, 1, 32'h100, Addi, 32'h104);
    add(0, 1, Addi,   1, 0, 32'h0,   0, 32'h104, 0, 0, 0, 0);
    add(1, 0, 32'h0,  1, 0, 32'h0,   1, 32'h108, 1, 32'h104, Addi, 32'h108);
    add(0, 1, Addi,   1, 0, 32'h0,   0, 32'h108, 0, 0, 0, 0);
    add(0, 0, 32'h0,  1, 1, 32'h200, 1, 32'h10C, 1, 32'h108, Addi, 32'h10C);
    add(1, 0, 32'h0,  1, 0, 32'h0,   1, 32'h200, 0, 0, 0, 0);
    add(0, 1, BeqM16, 1, 0, 32'h0,   0, 32'h200, 0, 0, 0, 0);
    add(0, 0, 32'h0,  1, 0, 32'h0,   1, 32'h1F0, 1, 32'h200, BeqM16, 32'h1F0);
    add(0, 0, 32'h0,  1, 1, 32'h300, 1, 32'h1F0, 0, 0, 0, 0);
    add(1, 0, 32'h0,  1, 0, 32'h0,   1, 32'h300, 0, 0, 0, 0);
    add(0, 1, Jal40,  1, 0, 32'h0,   0, 32'h300, 0, 0, 0, 0);
    add(1, 0, 32'h0,  0, 0, 32'h0,   1, 32'h340, 1, 32'h300, Jal40, 32'h340);
    add(0, 1, Addi,   0, 0, 32'h0,   0, 32'h340, 1, 32'h300, Jal40, 32'h340);
    add(0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h340, 1, 32'h300, Jal40, 32'h340);
    add(0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h340, 1, 32'h300, Jal40, 32'h340);
    add(0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h340, 1, 32'h300, Jal40, 32'h340);
    add(0, 0, 32'h0,  1, 0, 32'h0,   0, 32'h340, 1, 32'h300, Jal40, 32'h340);
    add(0, 0, 32'h0,  1, 0, 32'h0,   1, 32'h344, 1, 32'h340, Addi, 32'h344);
    add(1, 0, 32'h0,  1, 0, 32'h0,   1, 32'h344, 0, 0, 0, 0);
    add(0, 1, Addi,   1, 0, 32'h0,   0, 32'h344, 0, 0, 0, 0);
    add(0, 0, 32'h0,  1, 0, 32'h0,   1, 32'h348, 1, 32'h344, Addi, 32'h348);

    foreach (vt[i]) begin
      drive(vt[i].gnt, vt[i].rv, vt[i].rdata, vt[i].idr, vt[i].redir, vt[i].rpc);
      #1;
      chk($sformatf("row%0d_req", i), {31'h0, imem_req}, {31'h0, vt[i].e_req});
      chk($sformatf("row%0d_addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("row%0d_valid", i), {31'h0, if_valid}, {31'h0, vt[i].e_v});
      if (vt[i].e_v) begin
        chk($sformatf("row%0d_pc", i), if_pc, vt[i].e_pc);
        chk($sformatf("row%0d_instr", i), if_instr, vt[i].e_instr);
        chk($sformatf("row%0d_pred", i), if_pred_pc, vt[i].e_pred);
      end
      @(posedge clk);
      #1;
    end

    // ---------------- redirect one cycle after grant, slow response ----------------
    do_reset();
    step(1, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 1, 1, 32'h800);
    chk("drop_req0", {31'h0, imem_req}, 32'h0);
    chk("drop_valid0", {31'h0, if_valid}, 32'h0);
    step(0, 0, 32'h0, 1, 0, 32'h0);
    chk("drop_req1", {31'h0, imem_req}, 32'h0);
    step(0, 0, 32'h0, 1, 0, 32'h0);
    chk("drop_req2", {31'h0, imem_req}, 32'h0);
    step(0, 1, Jal40, 1, 0, 32'h0);
    chk("drop_stale_valid", {31'h0, if_valid}, 32'h0);
    chk("drop_resume_req", {31'h0, imem_req}, 32'h1);
    chk("drop_resume_addr", imem_addr, 32'h800);
    step(1, 0, 32'h0, 1, 0, 32'h0);
    step(0, 1, Addi, 1, 0, 32'h0);
    chk("drop_first_valid", {31'h0, if_valid}, 32'h1);
    chk("drop_first_pc", if_pc, 32'h800);
    chk("drop_first_instr", if_instr, Addi);
    chk("drop_next_addr", imem_addr, 32'h804);

    // redirect in the same cycle the request is granted
    step(1, 0, 32'h0, 1, 1, 32'h900);
    chk("gnt_redir_req", {31'h0, imem_req}, 32'h0);
    step(0, 1, BeqM16, 1, 0, 32'h0);
    chk("gnt_redir_valid", {31'h0, if_valid}, 32'h0);
    chk("gnt_redir_addr", imem_addr, 32'h900);

    // ---------------- redirect with rvalid while slot full and stalled ----------------
    do_reset();
    step(1, 0, 32'h0, 0, 0, 32'h0);
    step(0, 1, Addi, 0, 0, 32'h0);
    step(1, 0, 32'h0, 0, 0, 32'h0);
    step(0, 1, Jal40, 0, 1, 32'hA00);
    chk("wredir_valid", {31'h0, if_valid}, 32'h0);
    chk("wredir_req", {31'h0, imem_req}, 32'h1);
    chk("wredir_addr", imem_addr, 32'hA00);
    step(1, 0, 32'h0, 1, 0, 32'h0);
    step(0, 1, Addi, 1, 0, 32'h0);
    chk("wredir_pc", if_pc, 32'hA00);

    // ---------------- redirect while in HOLD ----------------
    do_reset();
    step(1, 0, 32'h0, 0, 0, 32'h0);
    step(0, 1, Addi, 0, 0, 32'h0);
    step(1, 0, 32'h0, 0, 0, 32'h0);
    step(0, 1, Jal40, 0, 0, 32'h0);
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    chk("hold_valid", {31'h0, if_valid}, 32'h1);
    step(0, 0, 32'h0, 0, 1, 32'hB00);
    chk("hredir_valid", {31'h0, if_valid}, 32'h0);
    chk("hredir_req", {31'h0, imem_req}, 32'h1);
    chk("hredir_addr", imem_addr, 32'hB00);
    step(1, 0, 32'h0, 1, 0, 32'h0);
    step(0, 1, Addi, 1, 0, 32'h0);
    chk("hredir_pc", if_pc, 32'hB00);
    chk("hredir_instr", if_instr, Addi);

    // ---------------- reset asserted mid-WAIT with a full slot ----------------
    do_reset();
    step(1, 0, 32'h0, 0, 0, 32'h0);
    step(0, 1, Jal40, 0, 0, 32'h0);
    step(1, 0, 32'h0, 0, 0, 32'h0);
    rst = 1'b1;
    step(0, 0, 32'h0, 0, 0, 32'h0);
    chk("mrst_req", {31'h0, imem_req}, 32'h0);
    chk("mrst_valid", {31'h0, if_valid}, 32'h0);
    chk("mrst_instr", if_instr, 32'h0);
    chk("mrst_pc", if_pc, 32'h0);
    chk("mrst_pred", if_pred_pc, 32'h0);
    chk("mrst_addr", imem_addr, RstPc);
    rst = 1'b0;
    #1;
    chk("mrst_first_req", {31'h0, imem_req}, 32'h1);

    // ---------------- randomized run against program-order stream ----------------
    begin
      logic        pending;
      int          cnt;
      logic [31:0] paddr;
      logic [31:0] exp_pc;
      logic        granted;
      logic        delivered;
      logic        prev_wait_req;
      logic [31:0] prev_addr;
      logic [31:0] ins;
      int          ndeliv;
      do_reset();
      pending       = 1'b0;
      cnt           = 0;
      paddr         = 32'h0;
      exp_pc        = RstPc;
      prev_wait_req = 1'b0;
      prev_addr     = 32'h0;
      ndeliv        = 0;
      for (int c = 0; c < 4000; c++) begin
        imem_rvalid    = pending && (cnt == 0);
        imem_rdata     = imem_rvalid ? memword(paddr) : $urandom;
        imem_gnt       = ($urandom % 10) < 7;
        id_ready       = ($urandom % 10) < 7;
        redirect_valid = ($urandom % 100) < 4;
        redirect_pc    = 32'h1000 + ($urandom_range(0, 1023) << 2);
        #1;
        if (imem_req && pending) chk("one_outstanding", {31'h0, imem_req}, 32'h0);
        if (prev_wait_req && imem_req) chk("addr_stable", imem_addr, prev_addr);
        delivered = if_valid && id_ready;
        if (delivered) begin
          ins = memword(exp_pc);
          chk("rnd_pc", if_pc, exp_pc);
          chk("rnd_instr", if_instr, ins);
          chk("rnd_pred", if_pred_pc, predict(exp_pc, ins));
          exp_pc = predict(exp_pc, ins);
          ndeliv++;
        end
        if (redirect_valid) exp_pc = redirect_pc;
        granted       = imem_req && imem_gnt;
        prev_wait_req = imem_req && !imem_gnt && !redirect_valid;
        prev_addr     = imem_addr;
        if (granted) paddr = imem_addr;
        @(posedge clk);
        #1;
        if (imem_rvalid) pending = 1'b0;
        else if (pending) cnt--;
        if (granted) begin
          pending = 1'b1;
          cnt     = $urandom_range(0, 2);
        end
      end
      chk("rnd_liveness", {31'h0, ndeliv > 200}, 32'h1);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
